// File: rtl/id_ex_pkg.sv
// Shared defaults and EX-control field layout for the ID/EX pipeline register.
package id_ex_pkg;

    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned IMM_W_DEF        = 16;
    localparam int unsigned REG_W_DEF        = 5;
    localparam int unsigned WB_W_DEF         = 2;
    localparam int unsigned M_W_DEF          = 3;
    localparam int unsigned ALUOP_W_DEF      = 2;
    localparam int unsigned EX_W_DEF         = ALUOP_W_DEF + 2;
    localparam int unsigned MEM_READ_IDX_DEF = 1;
    localparam int unsigned CNT_W_DEF        = 16;

    // EX control layout: [ALUOP_W-1:0] alu_op, then alu_src, then reg_dst.
    function automatic int unsigned alu_src_idx(int unsigned aluop_w);
        return aluop_w;
    endfunction

    function automatic int unsigned reg_dst_idx(int unsigned aluop_w);
        return aluop_w + 1;
    endfunction

    typedef enum logic [1:0] {
        ActHold   = 2'd0,
        ActBubble = 2'd1,
        ActLoad   = 2'd2
    } id_ex_action_e;

endpackage

// File: rtl/imm_extend.sv
// Combinational immediate extender: zero- or sign-extends IMM_W bits to DATA_W.
module imm_extend #(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic [IMM_W-1:0]  imm_i,
    input  logic              zext_i,
    output logic [DATA_W-1:0] imm_o
);

    logic fill;

    always_comb begin
        fill  = zext_i ? 1'b0 : imm_i[IMM_W-1];
        imm_o = {{(DATA_W-IMM_W){fill}}, imm_i};
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid bit, hold, flush, load-use bubble insertion
// and a saturating count of inserted bubbles.
module id_ex_stage_reg
    import id_ex_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned IMM_W        = IMM_W_DEF,
    parameter int unsigned REG_W        = REG_W_DEF,
    parameter int unsigned WB_W         = WB_W_DEF,
    parameter int unsigned M_W          = M_W_DEF,
    parameter int unsigned EX_W         = EX_W_DEF,
    parameter int unsigned ALUOP_W      = ALUOP_W_DEF,
    parameter int unsigned MEM_READ_IDX = MEM_READ_IDX_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               stall_in,
    input  logic               id_valid,
    input  logic [WB_W-1:0]    wb_in,
    input  logic [M_W-1:0]     m_in,
    input  logic [EX_W-1:0]    ex_in,
    input  logic               imm_zext,
    input  logic [DATA_W-1:0]  pc_in,
    input  logic [DATA_W-1:0]  read_data1_in,
    input  logic [DATA_W-1:0]  read_data2_in,
    input  logic [IMM_W-1:0]   imm_in,
    input  logic [REG_W-1:0]   rs_in,
    input  logic [REG_W-1:0]   rt_in,
    input  logic [REG_W-1:0]   rd_in,
    output logic               ex_valid,
    output logic [WB_W-1:0]    wb_out,
    output logic [M_W-1:0]     m_out,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_src,
    output logic               reg_dst,
    output logic [DATA_W-1:0]  pc_out,
    output logic [DATA_W-1:0]  read_data1_out,
    output logic [DATA_W-1:0]  read_data2_out,
    output logic [DATA_W-1:0]  imm_out,
    output logic [REG_W-1:0]   rs_out,
    output logic [REG_W-1:0]   rt_out,
    output logic [REG_W-1:0]   rd_out,
    output logic               hazard_stall,
    output logic [CNT_W-1:0]   bubble_count
);

    localparam int unsigned AluSrcIdx = alu_src_idx(ALUOP_W);
    localparam int unsigned RegDstIdx = reg_dst_idx(ALUOP_W);

    id_ex_action_e     action;
    logic [DATA_W-1:0] imm_ext;
    logic              cnt_sat;

    imm_extend #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_imm_extend (
        .imm_i  (imm_in),
        .zext_i (imm_zext),
        .imm_o  (imm_ext)
    );

    // Load-use: the instruction in EX is a load whose destination ID wants to read.
    always_comb begin
        hazard_stall = ex_valid & m_out[MEM_READ_IDX] & (rt_out != '0) & id_valid & ~flush &
                       ((rt_out == rs_in) | (rt_out == rt_in));
    end

    always_comb begin
        if (stall_in) begin
            action = ActHold;
        end else if (flush || hazard_stall) begin
            action = ActBubble;
        end else begin
            action = ActLoad;
        end
        cnt_sat = &bubble_count;
    end

    // Control fields and valid: zeroed on a bubble so nothing gets written downstream.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid <= 1'b0;
            wb_out   <= '0;
            m_out    <= '0;
            alu_op   <= '0;
            alu_src  <= 1'b0;
            reg_dst  <= 1'b0;
        end else begin
            unique case (action)
                ActHold: begin
                end
                ActBubble: begin
                    ex_valid <= 1'b0;
                    wb_out   <= '0;
                    m_out    <= '0;
                    alu_op   <= '0;
                    alu_src  <= 1'b0;
                    reg_dst  <= 1'b0;
                end
                default: begin
                    ex_valid <= id_valid;
                    wb_out   <= id_valid ? wb_in : '0;
                    m_out    <= id_valid ? m_in : '0;
                    alu_op   <= id_valid ? ex_in[ALUOP_W-1:0] : '0;
                    alu_src  <= id_valid & ex_in[AluSrcIdx];
                    reg_dst  <= id_valid & ex_in[RegDstIdx];
                end
            endcase
        end
    end

    // Data and index fields load on both bubbles and normal loads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_out         <= '0;
            read_data1_out <= '0;
            read_data2_out <= '0;
            imm_out        <= '0;
            rs_out         <= '0;
            rt_out         <= '0;
            rd_out         <= '0;
        end else if (action != ActHold) begin
            pc_out         <= pc_in;
            read_data1_out <= read_data1_in;
            read_data2_out <= read_data2_in;
            imm_out        <= imm_ext;
            rs_out         <= rs_in;
            rt_out         <= rt_in;
            rd_out         <= rd_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bubble_count <= '0;
        end else if (action == ActBubble && !cnt_sat) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

endmodule
